// File: rtl/fp_div_pkg.sv
// ---------------------------------------------------------------------------
// fp_div_pkg : shared types and constants for the FP32 divider arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fp_div_pkg;

  localparam int FP32_W = 32;

  localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [FP32_W-1:0] FP32_PINF = 32'h7F80_0000;
  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_WAIT_Z = 3'd3,
    ST_RESP   = 3'd4
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_div_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, first set bit at/after ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import fp_div_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int off = 0; off < N; off++) begin
      // ptr < N and off < N, so a single subtraction wraps the sum
      pos = {1'b0, ptr} + (IDX_W+1)'(off);
      if (pos >= (IDX_W+1)'(N)) begin
        pos = pos - (IDX_W+1)'(N);
      end
      if (!any && req[pos[IDX_W-1:0]]) begin
        any                     = 1'b1;
        idx                     = pos[IDX_W-1:0];
        grant[pos[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_div_arbiter.sv
// ---------------------------------------------------------------------------
// fp_div_arbiter : round-robin sharing of one FP32 divider among requesters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_div_arbiter
  import fp_div_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CYC_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [FP32_W*NUM_REQ-1:0]   req_a,
  input  logic [FP32_W*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [FP32_W-1:0]           rsp_z,
  output logic [CYC_W-1:0]            rsp_cycles,
  output logic                        div_rst,
  output logic [FP32_W-1:0]           div_input_a,
  output logic [FP32_W-1:0]           div_input_b,
  output logic                        div_input_a_stb,
  output logic                        div_input_b_stb,
  input  logic                        div_input_a_ack,
  input  logic                        div_input_b_ack,
  input  logic [FP32_W-1:0]           div_output_z,
  input  logic                        div_output_z_stb,
  output logic                        div_output_z_ack
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [FP32_W-1:0]  op_a_q, op_a_d;
  logic [FP32_W-1:0]  op_b_q, op_b_d;
  logic [FP32_W-1:0]  rsp_z_q, rsp_z_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d, cyc_inc;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               a_stb_q, a_stb_d;
  logic               b_stb_q, b_stb_d;
  logic               z_ack_q, z_ack_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign cyc_inc = (cyc_q == {CYC_W{1'b1}}) ? cyc_q : cyc_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_z_d     = rsp_z_q;
    cyc_d       = cyc_q;
    req_ready_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          req_ready_d = pick_grant;
          op_a_d      = req_a[int'(pick_idx)*FP32_W +: FP32_W];
          op_b_d      = req_b[int'(pick_idx)*FP32_W +: FP32_W];
          owner_d     = pick_idx;
          rr_ptr_d    = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
          cyc_d       = '0;
          state_d     = ST_SEND_A;
        end
      end
      ST_SEND_A: begin
        cyc_d = cyc_inc;
        if (a_stb_q && div_input_a_ack) state_d = ST_SEND_B;
      end
      ST_SEND_B: begin
        cyc_d = cyc_inc;
        if (b_stb_q && div_input_b_ack) state_d = ST_WAIT_Z;
      end
      ST_WAIT_Z: begin
        cyc_d = cyc_inc;
        if (z_ack_q && div_output_z_stb) begin
          rsp_z_d = div_output_z;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are registered copies of the state being entered
    a_stb_d     = (state_d == ST_SEND_A);
    b_stb_d     = (state_d == ST_SEND_B);
    z_ack_d     = (state_d == ST_WAIT_Z);
    rsp_valid_d = (state_d == ST_RESP) ? (NUM_REQ'(1) << owner_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_z_q     <= '0;
      cyc_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      a_stb_q     <= 1'b0;
      b_stb_q     <= 1'b0;
      z_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_z_q     <= rsp_z_d;
      cyc_q       <= cyc_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      a_stb_q     <= a_stb_d;
      b_stb_q     <= b_stb_d;
      z_ack_q     <= z_ack_d;
    end
  end

  assign div_rst          = !rst_n;
  assign req_ready        = req_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_z            = rsp_z_q;
  assign rsp_cycles       = cyc_q;
  assign div_input_a      = op_a_q;
  assign div_input_b      = op_b_q;
  assign div_input_a_stb  = a_stb_q;
  assign div_input_b_stb  = b_stb_q;
  assign div_output_z_ack = z_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_div_arbiter : directed self-checking bench with a behavioural divider
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp_div_arbiter;
  import fp_div_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int CYC_W     = 16;
  localparam int MODEL_LAT = 110;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [32*NUM_REQ-1:0]     req_a;
  logic [32*NUM_REQ-1:0]     req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [31:0]               rsp_z;
  logic [CYC_W-1:0]          rsp_cycles;
  logic                      div_rst;
  logic [31:0]               div_input_a, div_input_b;
  logic                      div_input_a_stb, div_input_b_stb;
  logic                      div_input_a_ack, div_input_b_ack;
  logic [31:0]               div_output_z;
  logic                      div_output_z_stb;
  logic                      div_output_z_ack;

  int checks = 0;
  int errors = 0;
  int b_delay = 0;

  fp_div_arbiter #(.NUM_REQ(NUM_REQ), .CYC_W(CYC_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_a            (req_a),
    .req_b            (req_b),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_z            (rsp_z),
    .rsp_cycles       (rsp_cycles),
    .div_rst          (div_rst),
    .div_input_a      (div_input_a),
    .div_input_b      (div_input_b),
    .div_input_a_stb  (div_input_a_stb),
    .div_input_b_stb  (div_input_b_stb),
    .div_input_a_ack  (div_input_a_ack),
    .div_input_b_ack  (div_input_b_ack),
    .div_output_z     (div_output_z),
    .div_output_z_stb (div_output_z_stb),
    .div_output_z_ack (div_output_z_ack)
  );

  always #5 clk = ~clk;

  // Hand-computed quotients for the operand pairs used below
  function automatic logic [31:0] div_table(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40C0_0000, 32'h4000_0000}: return 32'h4040_0000; // 6/2
      {32'h3F80_0000, 32'h0000_0000}: return FP32_PINF;     // 1/0
      {32'h4120_0000, 32'h40A0_0000}: return 32'h4000_0000; // 10/5
      {32'h4080_0000, 32'h4000_0000}: return 32'h4000_0000; // 4/2
      {32'h4100_0000, 32'h4000_0000}: return 32'h4080_0000; // 8/2
      {32'h4040_0000, 32'h3F80_0000}: return 32'h4040_0000; // 3/1
      {32'h4000_0000, 32'h4000_0000}: return 32'h3F80_0000; // 2/2
      default:                        return FP32_QNAN;
    endcase
  endfunction

  int          m_st;
  int          m_dly;
  int          m_lat;
  logic [31:0] m_a, m_b;

  always @(posedge clk) begin
    if (div_rst) begin
      m_st             <= 0;
      m_dly            <= 0;
      m_lat            <= 0;
      div_input_a_ack  <= 1'b0;
      div_input_b_ack  <= 1'b0;
      div_output_z_stb <= 1'b0;
      div_output_z     <= '0;
    end else begin
      case (m_st)
        0: begin
          if (div_input_a_ack && div_input_a_stb) begin
            m_a <= div_input_a; div_input_a_ack <= 1'b0; m_dly <= 0; m_st <= 1;
          end else begin
            div_input_a_ack <= 1'b1;
          end
        end
        1: begin
          if (div_input_b_ack && div_input_b_stb) begin
            m_b <= div_input_b; div_input_b_ack <= 1'b0; m_lat <= 0; m_st <= 2;
          end else if (m_dly >= b_delay) begin
            div_input_b_ack <= 1'b1;
          end else begin
            m_dly <= m_dly + 1;
          end
        end
        2: begin
          if (m_lat == MODEL_LAT) begin
            div_output_z <= div_table(m_a, m_b); div_output_z_stb <= 1'b1; m_st <= 3;
          end else begin
            m_lat <= m_lat + 1;
          end
        end
        default: begin
          if (div_output_z_stb && div_output_z_ack) begin
            div_output_z_stb <= 1'b0; m_st <= 0;
          end
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_valid[idx]      = 1'b1;
  endtask

  task automatic wait_grant(input int idx);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    check("grant", 32'(req_ready), 32'(1) << idx);
    req_valid[idx] = 1'b0;
  endtask

  // Waits for the response, optionally stalls it, then consumes it
  task automatic wait_rsp(input int idx, input logic [31:0] exp_z, input int hold);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (rsp_valid != '0) break;
    end
    check("rsp_valid", 32'(rsp_valid), 32'(1) << idx);
    check("rsp_z", rsp_z, exp_z);
    check("cycles_range", 32'(rsp_cycles > 100 && rsp_cycles < 200), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'(1) << idx);
      check("hold_z", rsp_z, exp_z);
      check("hold_no_grant", 32'(req_ready), 32'd0);
      check("hold_z_ack", 32'(div_output_z_ack), 32'd0);
    end
    rsp_ready[idx] = 1'b1;
    @(negedge clk);
    rsp_ready[idx] = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_strobes"}, {29'd0, div_input_a_stb, div_input_b_stb, div_output_z_ack}, 32'd0);
    check({tag, "_rsp_z"}, rsp_z, 32'd0);
    check({tag, "_cycles"}, 32'(rsp_cycles), 32'd0);
    check({tag, "_div_rst"}, 32'(div_rst), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [6] = '{0, 1, 2, 3, 0, 1};
    logic [31:0] rr_z [4] = '{32'h4000_0000, 32'h4080_0000, 32'h4040_0000, 32'h3F80_0000};
    int bad;
    int stall;

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;

    // Round-robin: all requesters valid from reset, results consumed at once
    set_req(0, 32'h4080_0000, 32'h4000_0000);
    set_req(1, 32'h4100_0000, 32'h4000_0000);
    set_req(2, 32'h4040_0000, 32'h3F80_0000);
    set_req(3, 32'h4000_0000, 32'h4000_0000);
    rsp_ready = '1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("div_rst_release", 32'(div_rst), 32'd0);
    for (int op = 0; op < 6; op++) begin
      for (int n = 0; n < 50 && req_ready == '0; n++) @(negedge clk);
      check("rr_order", 32'(req_ready), 32'(1) << order[op]);
      check("rr_onehot", 32'($countones(req_ready)), 32'd1);
      if (op == 5) req_valid = '0;
      for (int n = 0; n < 400 && rsp_valid == '0; n++) @(negedge clk);
      check("rr_rsp_valid", 32'(rsp_valid), 32'(1) << order[op]);
      check("rr_rsp_z", rsp_z, rr_z[order[op]]);
      @(negedge clk);
    end
    rsp_ready = '0;
    repeat (3) @(negedge clk);

    // Single division
    set_req(0, 32'h40C0_0000, 32'h4000_0000);
    wait_grant(0);
    wait_rsp(0, 32'h4040_0000, 0);

    // Division by zero, result passed through untouched
    set_req(2, 32'h3F80_0000, FP32_ZERO);
    wait_grant(2);
    wait_rsp(2, FP32_PINF, 0);

    // Response backpressure with another requester pending
    set_req(1, 32'h4100_0000, 32'h4000_0000);
    wait_grant(1);
    set_req(0, 32'h4080_0000, 32'h4000_0000);
    wait_rsp(1, 32'h4080_0000, 20);
    wait_grant(0);
    wait_rsp(0, 32'h4000_0000, 0);

    // Reset while waiting for the quotient
    set_req(0, 32'h40C0_0000, 32'h4000_0000);
    wait_grant(0);
    for (int n = 0; n < 50 && !div_output_z_ack; n++) @(negedge clk);
    check("in_wait_z", 32'(div_output_z_ack), 32'd1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (rsp_valid != '0) bad++;
    end
    check("no_rsp_after_rst", 32'(bad), 32'd0);
    set_req(0, 32'h4120_0000, 32'h40A0_0000);
    set_req(1, 32'h4100_0000, 32'h4000_0000);
    wait_grant(0);
    wait_rsp(0, 32'h4000_0000, 0);
    wait_grant(1);
    wait_rsp(1, 32'h4080_0000, 0);

    // Slow divider b ack
    b_delay = 5;
    set_req(3, 32'h4000_0000, 32'h4000_0000);
    wait_grant(3);
    for (int n = 0; n < 50 && !div_input_b_stb; n++) @(negedge clk);
    stall = 0;
    while (!(div_input_b_stb && div_input_b_ack) && stall < 50) begin
      check("b_stb_held", 32'(div_input_b_stb), 32'd1);
      check("b_stable", div_input_b, 32'h4000_0000);
      stall++;
      @(negedge clk);
    end
    check("b_stall_len", 32'(stall >= 4 && stall < 50), 32'd1);
    wait_rsp(3, 32'h3F80_0000, 0);
    b_delay = 0;

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_div_arbiter.md
# fp_div_arbiter

Round-robin scheduler that shares one IEEE-754 single-precision `divider` instance among `NUM_REQ` requesters. It accepts one (a, b) operand pair at a time from a requester and sequences the divider's get_a/get_b/put_z strobe-ack handshakes. It captures the quotient and returns it to the requester that issued the pair. It sits between client units and the divider, and also drives the divider's active-high reset.

## Interface
- `NUM_REQ`, default 4: number of requesters, 1..16.
- `CYC_W`, default 16: width of the per-operation latency counter.

- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NUM_REQ: requester i has an operand pair pending.
- `req_a` in 32*NUM_REQ: dividend for requester i, in slice [32i+31:32i].
- `req_b` in 32*NUM_REQ: divisor for requester i, in the same slicing.
- `req_ready` out NUM_REQ: one-hot acceptance pulse; requester i's pair is taken on this cycle.
- `rsp_valid` out NUM_REQ: one-hot; the result for requester i is available.
- `rsp_ready` in NUM_REQ: requester i consumes the result.
- `rsp_z` out 32: quotient bits, shared by all requesters.
- `rsp_cycles` out CYC_W: cycles from grant to divider z capture, saturating.
- `div_rst` out 1: divider reset, equal to `!rst_n` (combinational).
- `div_input_a`, `div_input_b` out 32: operands presented to the divider.
- `div_input_a_stb`, `div_input_b_stb` out 1: operand strobes to the divider.
- `div_input_a_ack`, `div_input_b_ack` in 1: operand acks from the divider.
- `div_output_z` in 32: divider result.
- `div_output_z_stb` in 1: divider result strobe.
- `div_output_z_ack` out 1: result ack to the divider.

## Operation
- FSM states: IDLE, SEND_A, SEND_B, WAIT_Z, RESP.
- **IDLE.** If any `req_valid` bit is set, grant the first set bit at or after `rr_ptr`, searching cyclically.
  - Pulse `req_ready[g]` for one cycle.
  - Latch `req_a[g]` and `req_b[g]` into the operand registers.
  - Set `owner<=g`, `rr_ptr<=(g+1) mod NUM_REQ`, clear the cycle counter, go to SEND_A.
  - With no request pending, stay in IDLE with all outputs low.
- **SEND_A.** Hold `div_input_a_stb=1` and keep `div_input_a` stable.
  - When `div_input_a_stb && div_input_a_ack` in the same cycle, the transfer occurs; go to SEND_B.
- **SEND_B.** Same rule using `div_input_b_stb` and `div_input_b_ack`; then go to WAIT_Z.
- **WAIT_Z.** Hold `div_output_z_ack=1`.
  - On `div_output_z_stb && div_output_z_ack`, capture `div_output_z` into `rsp_z`, freeze `rsp_cycles`, go to RESP.
- **RESP.** Hold `rsp_valid[owner]=1` and keep `rsp_z` stable.
  - On `rsp_ready[owner]`, go to IDLE.
  - `rsp_ready` bits other than `owner` are ignored.
- **Stalls.** `req_valid` may drop while a requester waits; it is only sampled in IDLE. No timeout applies in any state.
- **Result retention.** Results are passed through bit-exact; the arbiter does not inspect NaN, Inf or zero encodings. The divider is acked before the requester consumes the result, so requester backpressure never stalls the divider.
- **Cycle counter.** Increments in SEND_A, SEND_B and WAIT_Z and saturates at 2^CYC_W-1.

## Timing
- **Reset values** (`rst_n` low at a clock edge), effective after that edge:
  - state=IDLE, rr_ptr=0.
  - `req_ready`, `rsp_valid`, both operand strobes and `div_output_z_ack` are 0.
  - `rsp_z`=0, `rsp_cycles`=0.
  - `div_rst`=1 while `rst_n`=0.
- **Reset mid-operation** aborts any transaction in flight with no response; the divider is reset in the same cycles.
- **Arbiter overhead:**
  - Grant cycle T; `div_input_a_stb` goes high in T+1.
  - `rsp_valid` goes high 1 cycle after z capture.
  - The next grant is possible 1 cycle after the `rsp_ready` handshake; there is no back-to-back grant in the RESP exit cycle.
- All outputs are registered except `div_rst`.
- **Fairness:** a continuously requesting requester waits at most NUM_REQ-1 operations.

## Structure
- A shared package `fp_div_pkg` holds:
  - the FSM state enum `arb_state_t`;
  - `FP32_W=32`;
  - the `FP32_QNAN`, `FP32_PINF` and `FP32_ZERO` constants used by benches.
- One natural sub-module: `rr_pick`, a combinational round-robin priority picker (`req` vector plus pointer in, one-hot grant plus index out).
- The top-level integration instantiates `fp_div_arbiter` and `divider` side by side; the arbiter does not instantiate the divider.

## Test plan
1. **Single division.** Requester 0 sends a=0x40C00000, b=0x40000000. Expect `rsp_z`=0x40400000 (3.0) on `rsp_valid[0]`, and `rsp_cycles` > 100.
2. **Division by zero.** Requester 2 sends a=0x3F800000, b=0x00000000. Expect `rsp_z`=0x7F800000 on `rsp_valid[2]` only.
3. **Round-robin.** All 4 requesters hold `req_valid` from reset, with `rsp_ready` tied high. Expect the grant order 0,1,2,3,0,1, with exactly one `req_ready` bit per operation.
4. **Response backpressure.** `rsp_ready[1]` is held low for 20 cycles after `rsp_valid[1]` rises. Expect:
   - `rsp_valid[1]` and `rsp_z` held stable;
   - no `req_ready` during the hold;
   - `div_output_z_ack` low throughout RESP.
5. **Reset in WAIT_Z.** Assert `rst_n`=0 for 1 cycle during WAIT_Z. Expect:
   - state=IDLE with all outputs at reset values;
   - no `rsp_valid`;
   - a subsequent request, e.g. 0x41200000 / 0x40A00000, returns 0x40000000.
6. **Slow divider ack** (divider model delays `input_b_ack` by 5 cycles). Expect `div_input_b_stb` to stay high and `div_input_b` to stay stable until the handshake.
